// File: rtl/dual_ch_frame_packer_if.sv
// Bus bundle between the two ADC capture FIFOs, the frame packer and the
// host byte link.
//   master : packer side. Drives the FIFO rdreqs, the tx byte stream and the
//            status flags.
//   slave  : environment side. Drives the FIFO status/data and tx_ready.
// Signals:
//   chN_end/chN_empty/chN_data : FIFO capture-complete, empty and q (N=0,1)
//   chN_rdreq                  : FIFO read request (owned by the packer)
//   tx_data/tx_valid/tx_ready  : byte handshake to the host link
//   busy/frame_done/underrun   : packer status
interface dual_ch_frame_packer_if;
  logic       ch0_end;
  logic       ch0_empty;
  logic [7:0] ch0_data;
  logic       ch0_rdreq;
  logic       ch1_end;
  logic       ch1_empty;
  logic [7:0] ch1_data;
  logic       ch1_rdreq;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  modport master (
    input  ch0_end, ch0_empty, ch0_data, ch1_end, ch1_empty, ch1_data, tx_ready,
    output ch0_rdreq, ch1_rdreq, tx_data, tx_valid, busy, frame_done, underrun
  );

  modport slave (
    output ch0_end, ch0_empty, ch0_data, ch1_end, ch1_empty, ch1_data, tx_ready,
    input  ch0_rdreq, ch1_rdreq, tx_data, tx_valid, busy, frame_done, underrun
  );
endinterface

// File: rtl/dual_ch_frame_packer.sv
// Drains one of two ADC capture FIFOs per frame and emits the samples as a
// byte-framed packet on a valid/ready byte link:
//   HDR0 HDR1 CH_ID LEN_HI LEN_LO <FRAME_LEN samples> CSUM
// CSUM is the mod-256 sum of CH_ID, LEN_HI, LEN_LO and the samples.
// Channels are granted whole frames, round-robin when both request.
// Ports:
//   Clk     : system clock (shared with the FIFO domain)
//   Reset_n : asynchronous active-low reset
//   bus     : dual_ch_frame_packer_if.master (FIFO, tx link, status)
module dual_ch_frame_packer #(
  parameter int         FRAME_LEN = 256,
  parameter logic [7:0] HDR0      = 8'hA5,
  parameter logic [7:0] HDR1      = 8'h5A
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  dual_ch_frame_packer_if.master        bus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_HDR0  = 4'd1;
  localparam logic [3:0] S_HDR1  = 4'd2;
  localparam logic [3:0] S_CHID  = 4'd3;
  localparam logic [3:0] S_LENH  = 4'd4;
  localparam logic [3:0] S_LENL  = 4'd5;
  localparam logic [3:0] S_RD    = 4'd6;
  localparam logic [3:0] S_LATCH = 4'd7;
  localparam logic [3:0] S_SEND  = 4'd8;
  localparam logic [3:0] S_CSUM  = 4'd9;
  localparam logic [3:0] S_DONE  = 4'd10;

  localparam logic [15:0] LEN      = 16'(FRAME_LEN);
  localparam logic [15:0] LEN_LAST = 16'(FRAME_LEN - 1);

  logic [3:0]  r_state;
  logic        r_sel;
  logic        r_last;
  logic        r_busy;
  logic        r_und;
  logic        r_pad;
  logic        r_fdone;
  logic [7:0]  r_csum;
  logic [15:0] r_cnt;
  logic [7:0]  r_txd;
  logic        r_txv;

  logic       w_req0, w_req1, w_gnt, w_gsel;
  logic       w_sel_empty, w_acc, w_rd;
  logic [7:0] w_sel_data, w_chid, w_byte;

  assign w_req0 = bus.ch0_end & ~bus.ch0_empty;
  assign w_req1 = bus.ch1_end & ~bus.ch1_empty;
  assign w_gnt  = w_req0 | w_req1;
  // Both requesting: take the one not served last; otherwise whoever asks.
  assign w_gsel = (w_req0 & w_req1) ? ~r_last : w_req1;

  assign w_sel_empty = r_sel ? bus.ch1_empty : bus.ch0_empty;
  assign w_sel_data  = r_sel ? bus.ch1_data  : bus.ch0_data;
  assign w_chid      = {7'd0, r_sel};
  assign w_acc       = r_txv & bus.tx_ready;
  // FIFO q is valid the cycle after rdreq, i.e. in LATCH.
  assign w_byte      = r_pad ? 8'h00 : w_sel_data;

  // Combinational so the read is exactly the one RD cycle and is gated by the
  // live empty flag: no read is ever issued on an empty FIFO.
  assign w_rd          = (r_state == S_RD) & ~w_sel_empty;
  assign bus.ch0_rdreq = w_rd & ~r_sel;
  assign bus.ch1_rdreq = w_rd &  r_sel;

  assign bus.tx_data    = r_txd;
  assign bus.tx_valid   = r_txv;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_fdone;
  assign bus.underrun   = r_und;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_busy  <= 1'b0;
      r_und   <= 1'b0;
      r_pad   <= 1'b0;
      r_fdone <= 1'b0;
      r_csum  <= 8'h00;
      r_cnt   <= 16'd0;
      r_txd   <= 8'h00;
      r_txv   <= 1'b0;
    end else begin
      r_fdone <= 1'b0;
      case (r_state)
        S_IDLE: if (w_gnt) begin
          r_sel   <= w_gsel;
          r_last  <= w_gsel;
          r_busy  <= 1'b1;
          r_und   <= 1'b0;
          r_csum  <= 8'h00;
          r_cnt   <= 16'd0;
          r_txd   <= HDR0;
          r_txv   <= 1'b1;
          r_state <= S_HDR0;
        end
        // Header states: each one presents its byte and, on acceptance,
        // loads the next in the same edge so tx_valid stays high.
        S_HDR0: if (w_acc) begin
          r_txd   <= HDR1;
          r_state <= S_HDR1;
        end
        S_HDR1: if (w_acc) begin
          r_txd   <= w_chid;
          r_csum  <= r_csum + w_chid;
          r_state <= S_CHID;
        end
        S_CHID: if (w_acc) begin
          r_txd   <= LEN[15:8];
          r_csum  <= r_csum + LEN[15:8];
          r_state <= S_LENH;
        end
        S_LENH: if (w_acc) begin
          r_txd   <= LEN[7:0];
          r_csum  <= r_csum + LEN[7:0];
          r_state <= S_LENL;
        end
        S_LENL: if (w_acc) begin
          r_txv   <= 1'b0;
          r_state <= S_RD;
        end
        S_RD: begin
          r_pad   <= w_sel_empty;
          if (w_sel_empty) r_und <= 1'b1;
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_txd   <= w_byte;
          r_txv   <= 1'b1;
          r_csum  <= r_csum + w_byte;
          r_state <= S_SEND;
        end
        S_SEND: if (w_acc) begin
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == LEN_LAST) begin
            r_txd   <= r_csum;
            r_state <= S_CSUM;
          end else begin
            r_txv   <= 1'b0;
            r_state <= S_RD;
          end
        end
        S_CSUM: if (w_acc) begin
          r_txv   <= 1'b0;
          r_fdone <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_ch_frame_packer.sv
// Self-checking bench for dual_ch_frame_packer. Three instances share clock
// and reset: FRAME_LEN=4 (inst 0), 2 (inst 1), 300 (inst 2). Each has a
// behavioural FIFO pair in normal read mode. Expected bytes are queued when
// stimulus is set up and popped as the DUT hands bytes over.
module tb_dual_ch_frame_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0][1:0]      t_end, t_empty, t_rdreq;
  logic [2:0][1:0][7:0] t_q = '0;
  logic [2:0]           t_rdy, t_txv, t_busy, t_fd, t_und;
  logic [2:0][7:0]      t_txd;

  logic [7:0] fmem [3][2][512];
  int         fwp  [3][2] = '{default: 0};
  int         frp  [3][2] = '{default: 0};
  logic [7:0] expq [3][$];
  logic [7:0] smp  [$];
  int         rd_cnt [3][2] = '{default: 0};
  int         fd_cnt [3]    = '{default: 0};
  logic [2:0]      prev_stall = '0;
  logic [2:0][7:0] prev_d = '0;
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_s1 [10] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h04,
                              8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
  logic [7:0] exp_s3 [10] = '{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h04,
                              8'h10, 8'h20, 8'h00, 8'h00, 8'h35};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int FL = (g == 0) ? 4 : (g == 1) ? 2 : 300;
    dual_ch_frame_packer_if bus ();
    assign bus.ch0_end   = t_end[g][0];
    assign bus.ch0_empty = t_empty[g][0];
    assign bus.ch0_data  = t_q[g][0];
    assign bus.ch1_end   = t_end[g][1];
    assign bus.ch1_empty = t_empty[g][1];
    assign bus.ch1_data  = t_q[g][1];
    assign bus.tx_ready  = t_rdy[g];
    assign t_rdreq[g][0] = bus.ch0_rdreq;
    assign t_rdreq[g][1] = bus.ch1_rdreq;
    assign t_txd[g]      = bus.tx_data;
    assign t_txv[g]      = bus.tx_valid;
    assign t_busy[g]     = bus.busy;
    assign t_fd[g]       = bus.frame_done;
    assign t_und[g]      = bus.underrun;
    dual_ch_frame_packer #(.FRAME_LEN(FL), .HDR0(8'hA5), .HDR1(8'h5A)) u_dut (
      .Clk(clk), .Reset_n(rst_n), .bus(bus)
    );
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // FIFO model: q updates on the edge that samples rdreq.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 2; c++)
        if (t_rdreq[i][c] && frp[i][c] != fwp[i][c]) begin
          t_q[i][c] <= fmem[i][c][frp[i][c]];
          frp[i][c] <= frp[i][c] + 1;
        end
  end

  always_comb begin
    t_empty = '0;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 2; c++)
        t_empty[i][c] = (frp[i][c] == fwp[i][c]);
  end

  // Monitor: sampled mid-cycle, values hold until the next active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        prev_stall[i] <= 1'b0;
      end else begin
        if (prev_stall[i]) begin
          chk("hold_valid", int'(t_txv[i]), 1);
          chk("hold_data", int'(t_txd[i]), int'(prev_d[i]));
        end
        if (t_txv[i] && t_rdy[i]) begin
          if (expq[i].size() == 0) chk("unexpected_byte", int'(t_txd[i]), 'h100);
          else chk("byte", int'(t_txd[i]), int'(expq[i].pop_front()));
        end
        for (int c = 0; c < 2; c++)
          if (t_rdreq[i][c]) begin
            rd_cnt[i][c] <= rd_cnt[i][c] + 1;
            chk("rdreq_on_empty", int'(t_empty[i][c]), 0);
          end
        if (|t_rdreq[i]) chk("rdreq_excl", int'(&t_rdreq[i]), 0);
        if (t_fd[i]) fd_cnt[i] <= fd_cnt[i] + 1;
        prev_stall[i] <= t_txv[i] & ~t_rdy[i];
        prev_d[i]     <= t_txd[i];
      end
    end
  end

  task automatic push_fifo(input int i, input int c);
    foreach (smp[k]) begin
      fmem[i][c][fwp[i][c]] = smp[k];
      fwp[i][c]++;
    end
  endtask

  // Reference frame: samples from smp, zero-padded to fl.
  task automatic exp_frame(input int i, input int ch, input int fl);
    logic [7:0] cs, b;
    cs = ch[7:0] + fl[15:8] + fl[7:0];
    expq[i].push_back(8'hA5);
    expq[i].push_back(8'h5A);
    expq[i].push_back(ch[7:0]);
    expq[i].push_back(fl[15:8]);
    expq[i].push_back(fl[7:0]);
    for (int k = 0; k < fl; k++) begin
      b = (k < smp.size()) ? smp[k] : 8'h00;
      expq[i].push_back(b);
      cs = cs + b;
    end
    expq[i].push_back(cs);
  endtask

  task automatic wait_fd(input int i, input int tgt, input int budget);
    int n = 0;
    while (fd_cnt[i] < tgt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_done_cnt", fd_cnt[i], tgt);
  endtask

  task automatic chk_reset(input int i);
    chk("rst_tx_valid", int'(t_txv[i]), 0);
    chk("rst_tx_data", int'(t_txd[i]), 0);
    chk("rst_busy", int'(t_busy[i]), 0);
    chk("rst_frame_done", int'(t_fd[i]), 0);
    chk("rst_underrun", int'(t_und[i]), 0);
    chk("rst_rdreq", int'(t_rdreq[i]), 0);
  endtask

  initial begin
    int n;
    t_end = '0;
    t_rdy = '1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) chk_reset(i);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: basic ch0 frame
    smp = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_fifo(0, 0);
    foreach (exp_s1[k]) expq[0].push_back(exp_s1[k]);
    t_end[0][0] = 1'b1;
    wait_fd(0, 1, 200);
    t_end[0][0] = 1'b0;
    chk("s1_rd_ch0", rd_cnt[0][0], 4);
    chk("s1_rd_ch1", rd_cnt[0][1], 0);
    chk("s1_underrun", int'(t_und[0]), 0);
    chk("s1_busy_idle", int'(t_busy[0]), 0);
    chk("s1_left", expq[0].size(), 0);

    // 3: ch1 short FIFO, padded frame
    smp = '{8'h10, 8'h20};
    push_fifo(0, 1);
    foreach (exp_s3[k]) expq[0].push_back(exp_s3[k]);
    t_end[0][1] = 1'b1;
    wait_fd(0, 2, 200);
    t_end[0][1] = 1'b0;
    chk("s3_rd_ch1", rd_cnt[0][1], 2);
    chk("s3_underrun", int'(t_und[0]), 1);
    chk("s3_left", expq[0].size(), 0);

    // 4: random backpressure, same stream as scenario 1
    smp = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_fifo(0, 0);
    foreach (exp_s1[k]) expq[0].push_back(exp_s1[k]);
    t_end[0][0] = 1'b1;
    n = 0;
    while (fd_cnt[0] < 3 && n < 600) begin
      @(posedge clk); #1;
      t_rdy[0] = 1'($urandom_range(1, 0));
      n++;
    end
    t_rdy[0] = 1'b1;
    t_end[0][0] = 1'b0;
    chk("s4_frame_done_cnt", fd_cnt[0], 3);
    chk("s4_rd_ch0", rd_cnt[0][0], 8);
    chk("s4_underrun_cleared", int'(t_und[0]), 0);
    chk("s4_left", expq[0].size(), 0);

    // 5: async reset while a sample byte is presented
    smp = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_fifo(0, 0);
    expq[0].push_back(8'hA5); expq[0].push_back(8'h5A); expq[0].push_back(8'h00);
    expq[0].push_back(8'h00); expq[0].push_back(8'h04); expq[0].push_back(8'h01);
    t_end[0][0] = 1'b1;
    n = 0;
    while (rd_cnt[0][0] < 10 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s5_second_read", rd_cnt[0][0], 10);
    @(posedge clk); #1;
    chk("s5_pre_valid", int'(t_txv[0]), 1);
    chk("s5_pre_data", int'(t_txd[0]), 8'h02);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk_reset(i);
    chk("s5_left", expq[0].size(), 0);
    // FIFO still holds 03 04; top it up so the next frame is full
    smp = '{8'h05, 8'h06};
    push_fifo(0, 0);
    smp = '{8'h03, 8'h04, 8'h05, 8'h06};
    exp_frame(0, 0, 4);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fd(0, 4, 200);
    t_end[0][0] = 1'b0;
    chk("s5_rd_ch0", rd_cnt[0][0], 14);
    chk("s5_underrun", int'(t_und[0]), 0);
    chk("s5_left_after", expq[0].size(), 0);

    // 2: both channels request together, FRAME_LEN=2
    smp = '{8'h11, 8'h22};
    push_fifo(1, 0);
    exp_frame(1, 0, 2);
    smp = '{8'h33, 8'h44};
    push_fifo(1, 1);
    exp_frame(1, 1, 2);
    t_end[1] = 2'b11;
    wait_fd(1, 2, 300);
    t_end[1] = 2'b00;
    chk("s2_rd_ch0", rd_cnt[1][0], 2);
    chk("s2_rd_ch1", rd_cnt[1][1], 2);
    chk("s2_underrun", int'(t_und[1]), 0);
    chk("s2_left", expq[1].size(), 0);

    // 6: FRAME_LEN=300, checksum wraps
    smp.delete();
    for (int k = 0; k < 300; k++) smp.push_back(k[7:0]);
    push_fifo(2, 0);
    exp_frame(2, 0, 300);
    t_end[2][0] = 1'b1;
    wait_fd(2, 1, 3000);
    t_end[2][0] = 1'b0;
    chk("s6_rd_ch0", rd_cnt[2][0], 300);
    chk("s6_underrun", int'(t_und[2]), 0);
    chk("s6_left", expq[2].size(), 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
